// File: rtl/fe_mpa_pkg.sv
// fe_mpa_pkg: shared constants, FSM states and output word packing for the MPA hit receiver.
package fe_mpa_pkg;
    localparam int HIT_W = 17;
    localparam int Z_LSB = 13;
    localparam int PHI_LSB = 5;
    localparam int BEND_LSB = 0;
    localparam logic TYPE_HIT = 1'b0;
    localparam logic TYPE_TRL = 1'b1;
    typedef enum logic [1:0] {IDLE, DRAIN, TRAIL} state_t;
    // Low part of an output word: {slot, z, phi, bend}; type and timestamp are prepended by the caller.
    function automatic logic [HIT_W+1:0] pack_tail(input logic [1:0] slot, input logic [HIT_W-1:0] hit);
        return {slot, hit[Z_LSB +: 4], hit[PHI_LSB +: 8], hit[BEND_LSB +: 5]};
    endfunction
endpackage

// File: rtl/fe_mpa_rx_fifo.sv
// fe_mpa_rx_fifo: first-word-fall-through synchronous FIFO with full/empty flags.
module fe_mpa_rx_fifo #(
    parameter int W = 32,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout = empty ? '0 : mem[rp[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/fe_mpa_rx.sv
// fe_mpa_rx: captures four MPA hit ports per BX, timestamps and serialises them into a FWFT FIFO.
// Optional BX trailer word enabled by FE_MPA_RX_TRAILER_EN.
module fe_mpa_rx
    import fe_mpa_pkg::*;
#(
    parameter int TS_W = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int OVF_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             hit1_dv,
    input  logic [16:0]      hit1_data,
    input  logic             hit2_dv,
    input  logic [16:0]      hit2_data,
    input  logic             hit3_dv,
    input  logic [16:0]      hit3_data,
    input  logic             hit4_dv,
    input  logic [16:0]      hit4_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TS_W+19:0] out_data,
    output logic [TS_W-1:0]  ts_cnt,
    output logic [OVF_W-1:0] ovf_cnt,
    output logic             ovf_sticky
);
    logic [HIT_W-1:0] stage [4];
    logic [3:0] mask, mask_nx, dv;
    logic [TS_W-1:0] stage_ts;
    logic [1:0] sel;
    logic [2:0] lost;
    logic [OVF_W:0] ovf_sum;
    logic push_hit, push, full, empty;
    logic [TS_W+19:0] din;
    state_t st, st_nx;
    assign dv = {hit4_dv, hit3_dv, hit2_dv, hit1_dv};
    assign sel = mask[0] ? 2'd0 : mask[1] ? 2'd1 : mask[2] ? 2'd2 : 2'd3;
    assign push_hit = |mask && !full;
    assign mask_nx = push_hit ? mask & ~(4'b1 << sel) : mask;
    // Hits still staged after this cycle's push are lost if a new BX is captured now.
    assign lost = {2'b0, mask_nx[0]} + {2'b0, mask_nx[1]} + {2'b0, mask_nx[2]} + {2'b0, mask_nx[3]};
    assign ovf_sum = {1'b0, ovf_cnt} + {{(OVF_W-2){1'b0}}, lost};
`ifdef FE_MPA_RX_TRAILER_EN
    localparam state_t DONE_ST = TRAIL;
    logic [2:0] cnt;
    logic push_trl;
    assign push_trl = st == TRAIL && !full;
    assign push = push_hit || push_trl;
    assign din = push_trl ? {TYPE_TRL, stage_ts, pack_tail(2'd0, {14'b0, cnt})}
                          : {TYPE_HIT, stage_ts, pack_tail(sel, stage[sel])};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (en) cnt <= '0;
        else if (push_hit) cnt <= cnt + 1'b1;
    end
`else
    localparam state_t DONE_ST = IDLE;
    assign push = push_hit;
    assign din = {TYPE_HIT, stage_ts, pack_tail(sel, stage[sel])};
`endif
    always_comb begin
        st_nx = st;
        if (en) st_nx = |dv ? DRAIN : IDLE;
        else if (st == DRAIN && mask_nx == '0) st_nx = DONE_ST;
`ifdef FE_MPA_RX_TRAILER_EN
        else if (push_trl) st_nx = IDLE;
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
            mask <= '0;
            stage_ts <= '0;
            ts_cnt <= '0;
            ovf_cnt <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            st <= st_nx;
            mask <= en ? dv : mask_nx;
            if (en) begin
                stage_ts <= ts_cnt;
                ts_cnt <= ts_cnt + 1'b1;
                ovf_cnt <= ovf_sum[OVF_W] ? '1 : ovf_sum[OVF_W-1:0];
                if (|lost) ovf_sticky <= 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (en) stage <= '{hit1_data, hit2_data, hit3_data, hit4_data};
    end
    assign out_valid = !empty;
    fe_mpa_rx_fifo #(.W(TS_W + 20), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .din(din),
        .pop(out_valid && out_ready),
        .dout(out_data),
        .full(full),
        .empty(empty)
    );
endmodule

// File: tb/tb_fe_mpa_rx.sv
// tb_fe_mpa_rx: directed self-checking bench for fe_mpa_rx (default build, or trailer build with FE_MPA_RX_TRAILER_EN).
module tb_fe_mpa_rx;
    logic clk = 1'b0;
    logic rst_n, en, out_ready, out_valid, ovf_sticky;
    logic [3:0] dv;
    logic [16:0] hd [4];
    logic [31:0] out_data;
    logic [11:0] ts_cnt;
    logic [7:0] ovf_cnt;
    int nvec = 0;
    int nerr = 0;

    fe_mpa_rx dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hit1_dv(dv[0]), .hit1_data(hd[0]),
        .hit2_dv(dv[1]), .hit2_data(hd[1]),
        .hit3_dv(dv[2]), .hit3_data(hd[2]),
        .hit4_dv(dv[3]), .hit4_data(hd[3]),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ts_cnt(ts_cnt), .ovf_cnt(ovf_cnt), .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] w(input logic t, input logic [11:0] ts, input logic [1:0] s, input logic [16:0] d);
        return {t, ts, s, d};
    endfunction

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        dv = 4'b0;
        hd = '{default: 17'h0};
        out_ready = 1'b0;
        repeat (2) tick();
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_ts", {20'b0, ts_cnt}, 32'd0);
        chk("rst_ovf", {24'b0, ovf_cnt}, 32'd0);
        chk("rst_sticky", {31'b0, ovf_sticky}, 32'd0);
        rst_n = 1'b1;
        tick();
`ifdef FE_MPA_RX_TRAILER_EN
        out_ready = 1'b1;
        en = 1'b1;
        repeat (7) tick();
        en = 1'b0;
        repeat (2) tick();
        chk("empty_bx_no_trl", {31'b0, out_valid}, 32'd0);
        chk("trl_ts7", {20'b0, ts_cnt}, 32'd7);
        dv = 4'b0111;
        hd[0] = 17'h00011; hd[1] = 17'h00022; hd[2] = 17'h00033;
        en = 1'b1;
        tick();
        en = 1'b0;
        dv = 4'b0;
        tick();
        chk("trl_h0", out_data, w(1'b0, 12'h007, 2'd0, 17'h00011));
        tick();
        chk("trl_h1", out_data, w(1'b0, 12'h007, 2'd1, 17'h00022));
        tick();
        chk("trl_h2", out_data, w(1'b0, 12'h007, 2'd2, 17'h00033));
        tick();
        chk("trl_word", out_data, w(1'b1, 12'h007, 2'd0, 17'd3));
        tick();
        chk("trl_done", {31'b0, out_valid}, 32'd0);
`else
        // single hit: latency and format
        out_ready = 1'b1;
        en = 1'b1; dv = 4'b0001; hd[0] = 17'h1ABCD;
        tick();
        en = 1'b0; dv = 4'b0;
        chk("lat_not_yet", {31'b0, out_valid}, 32'd0);
        chk("ts_after_1", {20'b0, ts_cnt}, 32'd1);
        tick();
        chk("t1_valid", {31'b0, out_valid}, 32'd1);
        chk("t1_data", out_data, w(1'b0, 12'h000, 2'd0, 17'h1ABCD));
        tick();
        chk("t1_drained", {31'b0, out_valid}, 32'd0);
        // sparse slots at ts 5
        en = 1'b1;
        repeat (4) tick();
        dv = 4'b1010; hd[1] = 17'h00222; hd[3] = 17'h00444;
        tick();
        en = 1'b0; dv = 4'b0;
        tick();
        chk("t2_slot1", out_data, w(1'b0, 12'h005, 2'd1, 17'h00222));
        tick();
        chk("t2_slot3", out_data, w(1'b0, 12'h005, 2'd3, 17'h00444));
        tick();
        chk("t2_drained", {31'b0, out_valid}, 32'd0);
        chk("t2_ovf", {24'b0, ovf_cnt}, 32'd0);
        // continuous overrun: 10 overruns of 3 hits each
        dv = 4'hF; en = 1'b1;
        repeat (11) tick();
        en = 1'b0; dv = 4'b0;
        chk("t3_ovf30", {24'b0, ovf_cnt}, 32'd30);
        chk("t3_sticky", {31'b0, ovf_sticky}, 32'd1);
        repeat (6) tick();
        chk("t3_drained", {31'b0, out_valid}, 32'd0);
        chk("t3_ts", {20'b0, ts_cnt}, 32'd17);
        // back-pressure: fill 16 entries, stage 4 more
        out_ready = 1'b0;
        for (int b = 0; b < 5; b++) begin
            for (int s = 0; s < 4; s++) hd[s] = 17'h10000 | 17'(b << 4) | 17'(s);
            dv = 4'hF; en = 1'b1;
            tick();
            en = 1'b0; dv = 4'b0;
            if (b < 4) repeat (4) tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk("t4_stall_valid", {31'b0, out_valid}, 32'd1);
            chk("t4_stall_data", out_data, w(1'b0, 12'd17, 2'd0, 17'h10000));
            tick();
        end
        chk("t4_ovf_hold", {24'b0, ovf_cnt}, 32'd30);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("t4_word", out_data, w(1'b0, 12'(17 + i / 4), 2'(i % 4), 17'h10000 | 17'((i / 4) << 4) | 17'(i % 4)));
            tick();
        end
        chk("t4_drained", {31'b0, out_valid}, 32'd0);
        chk("t4_no_loss", {24'b0, ovf_cnt}, 32'd30);
        // timestamp wrap
        en = 1'b1;
        repeat (4073) tick();
        en = 1'b0;
        chk("t5_ts_fff", {20'b0, ts_cnt}, 32'hFFF);
        en = 1'b1; dv = 4'b0001; hd[0] = 17'h0AAAA;
        tick();
        hd[0] = 17'h05555;
        tick();
        en = 1'b0; dv = 4'b0;
        chk("t5_word_fff", out_data, w(1'b0, 12'hFFF, 2'd0, 17'h0AAAA));
        chk("t5_ts_after", {20'b0, ts_cnt}, 32'd1);
        tick();
        chk("t5_word_000", out_data, w(1'b0, 12'h000, 2'd0, 17'h05555));
        tick();
        chk("t5_drained", {31'b0, out_valid}, 32'd0);
        // reset in mid-drain discards everything, counts nothing
        out_ready = 1'b0;
        en = 1'b1; dv = 4'hF;
        tick();
        en = 1'b0; dv = 4'b0;
        tick();
        chk("t6_pre_valid", {31'b0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("t6_rst_ovf", {24'b0, ovf_cnt}, 32'd0);
        chk("t6_rst_sticky", {31'b0, ovf_sticky}, 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("t6_discarded", {31'b0, out_valid}, 32'd0);
        chk("t6_ovf_zero", {24'b0, ovf_cnt}, 32'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
